// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer window reader.
//   ZOOM_X1/X2/X4 : encodings of the zoom input (3 is reserved and behaves as x1)
//   COORD_W       : width of raster coordinates and window offsets
//   zoom_shift()  : maps a zoom code to log2 of the zoom factor
package fb_pkg;

    localparam int COORD_W = 10;

    localparam logic [1:0] ZOOM_X1 = 2'd0;
    localparam logic [1:0] ZOOM_X2 = 2'd1;
    localparam logic [1:0] ZOOM_X4 = 2'd2;

    function automatic logic [1:0] zoom_shift(input logic [1:0] zoom);
        case (zoom)
            ZOOM_X2: zoom_shift = 2'd1;
            ZOOM_X4: zoom_shift = 2'd2;
            default: zoom_shift = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register that carries per-pixel flags alongside the
// framebuffer read so they meet rd_data in the same cycle.
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset, clears every stage
//   din     : flags entering the line
//   dout    : flags delayed by DEPTH cycles
module fb_delay_line
    import fb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fb_window_reader.sv
// Framebuffer read front-end: converts raster coordinates into read addresses
// for a positioned, integer-zoomed image window and returns the pixel colour
// (or background) RAM_LAT+2 cycles later. Addresses are built incrementally
// from a per-row base, so no multiplier is needed.
//   clk         : pixel clock
//   reset_n     : asynchronous active-low reset
//   pix_valid   : next_x/next_y is a requested pixel this cycle
//   next_x/y    : raster column / row
//   zoom        : 0 x1, 1 x2, 2 x4, 3 treated as x1
//   x_off/y_off : window top-left corner in screen pixels
//   rd_addr     : framebuffer read address (0 outside the window)
//   rd_data     : framebuffer read data, RAM_LAT cycles after rd_addr
//   color_out   : pixel colour, qualified by color_valid
//   frame_start : one-cycle pulse the cycle after (0,0) is accepted
// Build option: define FB_BORDER_EN to paint a 1-pixel BORDER_COLOR frame
// around the window.
module fb_window_reader
    import fb_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 8,
    parameter int RAM_LAT = 1,
    parameter logic [PIX_W-1:0] BG_COLOR     = '0,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] next_x,
    input  logic [COORD_W-1:0] next_y,
    input  logic [1:0]         zoom,
    input  logic [COORD_W-1:0] x_off,
    input  logic [COORD_W-1:0] y_off,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic [PIX_W-1:0]   color_out,
    output logic               color_valid,
    output logic               frame_start
);

    // Two spare bits so offset + zoomed extent never wraps.
    localparam int CW = COORD_W + 2;

`ifdef FB_BORDER_EN
    localparam int FLAG_W = 3;
`else
    localparam int FLAG_W = 2;
`endif

    logic [COORD_W-1:0] sh_x_off, sh_y_off;
    logic [1:0]         sh_zoom;
    logic [ADDR_W-1:0]  line_base, lb_next, addr_next;
    logic [1:0]         sub, sub_next, sub_max;

    logic               accept, fs;
    logic [COORD_W-1:0] eff_x_off, eff_y_off;
    logic [1:0]         eff_zoom, zs;
    logic [CW-1:0]      x_c, y_c, xo, yo, x_end, y_end, x_rel;
    logic               in_x, in_y, in_win, border;

    logic [FLAG_W-1:0]  flags_in, flags_out;

    assign accept = pix_valid && ({2'b00, next_x} < CW'(SCR_W))
                              && ({2'b00, next_y} < CW'(SCR_H));
    assign fs     = accept && (next_x == '0) && (next_y == '0);

    // The frame-start pixel itself must already use the freshly latched values.
    assign eff_x_off = fs ? x_off : sh_x_off;
    assign eff_y_off = fs ? y_off : sh_y_off;
    assign eff_zoom  = fs ? zoom  : sh_zoom;
    assign zs        = zoom_shift(eff_zoom);
    assign sub_max   = 2'((3'd1 << zs) - 3'd1);

    assign x_c   = CW'(next_x);
    assign y_c   = CW'(next_y);
    assign xo    = CW'(eff_x_off);
    assign yo    = CW'(eff_y_off);
    assign x_end = xo + (CW'(IMG_W) << zs);
    assign y_end = yo + (CW'(IMG_H) << zs);

    assign in_x   = (x_c >= xo) && (x_c < x_end);
    assign in_y   = (y_c >= yo) && (y_c < y_end);
    assign in_win = accept && in_x && in_y;

    // Row tracking happens on column 0 regardless of horizontal clipping, so
    // line_base stays correct even when the window starts right of x=0.
    always_comb begin
        lb_next  = line_base;
        sub_next = sub;
        if (accept && (next_x == '0)) begin
            if (y_c == yo) begin
                lb_next  = '0;
                sub_next = '0;
            end else if (in_y) begin
                if (sub >= sub_max) begin
                    sub_next = '0;
                    lb_next  = line_base + ADDR_W'(IMG_W);
                end else begin
                    sub_next = sub + 2'd1;
                end
            end
        end
    end

    assign x_rel     = (x_c - xo) >> zs;
    assign addr_next = lb_next + ADDR_W'(x_rel);

`ifdef FB_BORDER_EN
    logic ext_x, ext_y;
    // x+1 >= xo avoids underflow of xo-1 when the window touches the left edge.
    assign ext_x    = (x_c + CW'(1) >= xo) && (x_c <= x_end);
    assign ext_y    = (y_c + CW'(1) >= yo) && (y_c <= y_end);
    assign border   = accept && ext_x && ext_y && !(in_x && in_y);
    assign flags_in = {border, in_win, accept};
`else
    logic [PIX_W-1:0] unused_border_color;
    assign unused_border_color = BORDER_COLOR;
    assign border   = 1'b0;
    assign flags_in = {in_win, accept};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x_off    <= COORD_W'((SCR_W - IMG_W) / 2);
            sh_y_off    <= COORD_W'((SCR_H - IMG_H) / 2);
            sh_zoom     <= ZOOM_X1;
            line_base   <= '0;
            sub         <= '0;
            rd_addr     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (fs) begin
                sh_x_off <= x_off;
                sh_y_off <= y_off;
                sh_zoom  <= zoom;
            end
            line_base   <= lb_next;
            sub         <= sub_next;
            rd_addr     <= in_win ? addr_next : '0;
            frame_start <= fs;
        end
    end

    fb_delay_line #(
        .DEPTH (RAM_LAT + 1),
        .WIDTH (FLAG_W)
    ) u_flags (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (flags_in),
        .dout    (flags_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= flags_out[0];
`ifdef FB_BORDER_EN
            color_out   <= flags_out[1] ? rd_data :
                           flags_out[2] ? BORDER_COLOR : BG_COLOR;
`else
            color_out   <= flags_out[1] ? rd_data : BG_COLOR;
`endif
        end
    end

endmodule
